// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: opcodes, FSM states, widths.
package hazard_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STALL_W = 32;

  // RISC-V base opcodes, same set the decoder uses
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_e;

  // Pipeline control bundle driven towards fetch/decode
  typedef struct packed {
    logic ide_wait;
    logic pc_hold;
    logic flush_if;
  } ctl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [XLEN-1:0]    instr_id;
  logic               id_valid;
  logic [OPC_W-1:0]   opcode_id2exe;
  logic [REG_W-1:0]   wr_addr_id2exe;
  logic               mispredict;
  logic               exe_mem_req;
  logic               dmem_ready;
  logic               ide_wait;
  logic               pc_hold;
  logic               flush_if;
  logic               mem_err;
  logic [STALL_W-1:0] stall_count;

  // Pipeline side
  modport master (
    output instr_id, id_valid, opcode_id2exe, wr_addr_id2exe,
    output mispredict, exe_mem_req, dmem_ready,
    input  ide_wait, pc_hold, flush_if, mem_err, stall_count
  );

  // Controller side
  modport slave (
    input  instr_id, id_valid, opcode_id2exe, wr_addr_id2exe,
    input  mispredict, exe_mem_req, dmem_ready,
    output ide_wait, pc_hold, flush_if, mem_err, stall_count
  );

endinterface

// File: rtl/hazard_ctrl_opuse.sv
// Source-operand usage decode from an opcode; shared with forwarding logic.
module hazard_ctrl_opuse
  import hazard_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             uses_rs1,
  output logic             uses_rs2
);

  // rs1 read by everything except upper-immediate and JAL; rs2 only by R/S/B formats
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL:            uses_rs1 = 1'b0;
      OPC_OP, OPC_STORE, OPC_BRANCH:          uses_rs2 = 1'b1;
      OPC_LOAD, OPC_JALR, OPC_OP_IMM:         uses_rs1 = 1'b1;
      default:                                uses_rs1 = 1'b1;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, mispredict flushes, memory-wait holds.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned      FLUSH_CYCLES = 2,
  parameter int unsigned      MEM_TIMEOUT  = 15,
  parameter logic [OPC_W-1:0] LOAD_OPC     = OPC_LOAD
) (
  input  logic         clk,
  input  logic         rstn,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned CMP_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] FLUSH_FULL   = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CMP_W-1:0] TIMEOUT      = CMP_W'(MEM_TIMEOUT);
  localparam bit               FLUSH_MULTI  = (FLUSH_CYCLES > 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               mem_err_q, err_set;
  logic [STALL_W-1:0] stall_q;
  ctl_t               ctl;

  logic               uses_rs1, uses_rs2;
  logic               ld_use_c, mw_pend_c, mw_timeout_c;
  logic [REG_W-1:0]   rs1, rs2;
  logic               unused_instr_bits;

  hazard_ctrl_opuse u_opuse (
    .opcode   (hz.instr_id[6:0]),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign rs1 = hz.instr_id[19:15];
  assign rs2 = hz.instr_id[24:20];
  assign unused_instr_bits = ^{hz.instr_id[31:25], hz.instr_id[14:7]};

  // Decode operand reads against a pending load destination; x0 never conflicts
  assign ld_use_c = hz.id_valid && (hz.opcode_id2exe == LOAD_OPC) &&
                    (hz.wr_addr_id2exe != '0) &&
                    ((uses_rs1 && (rs1 == hz.wr_addr_id2exe)) ||
                     (uses_rs2 && (rs2 == hz.wr_addr_id2exe)));

  // Memory-wait bookkeeping: flush owed on exit, and give-up point
  assign mw_pend_c    = pend_q | hz.mispredict;
  assign mw_timeout_c = ({1'b0, cnt_q} + CMP_W'(1)) >= TIMEOUT;

  // Next state, counters and same-cycle control outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_set = 1'b0;
    ctl     = '0;
    case (state_q)
      ST_RUN, ST_LDUSE: begin
        if (hz.mispredict) begin
          ctl.flush_if = 1'b1;
          ctl.ide_wait = 1'b1;
          cnt_d        = FLUSH_RELOAD;
          state_d      = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_LDUSE) begin
          state_d = ST_RUN;
        end else if (hz.exe_mem_req && !hz.dmem_ready) begin
          ctl.ide_wait = 1'b1;
          ctl.pc_hold  = 1'b1;
          cnt_d        = CNT_W'(1);
          state_d      = ST_MEMWAIT;
        end else if (ld_use_c) begin
          ctl.ide_wait = 1'b1;
          ctl.pc_hold  = 1'b1;
          state_d      = ST_LDUSE;
        end
      end
      ST_FLUSH: begin
        ctl.ide_wait = 1'b1;
        if (hz.mispredict) begin
          ctl.flush_if = 1'b1;
          cnt_d        = FLUSH_RELOAD;
          state_d      = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        ctl.ide_wait = 1'b1;
        ctl.pc_hold  = 1'b1;
        pend_d       = mw_pend_c;
        if (hz.dmem_ready || mw_timeout_c) begin
          err_set = !hz.dmem_ready;
          pend_d  = 1'b0;
          if (mw_pend_c) begin
            ctl.flush_if = 1'b1;
            cnt_d        = FLUSH_FULL;
            state_d      = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, counters, sticky error and saturating stall counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      mem_err_q <= mem_err_q | err_set;
      if (ctl.ide_wait && (stall_q != '1)) stall_q <= stall_q + STALL_W'(1);
    end
  end

  // Controls drop the instant reset is asserted
  assign hz.ide_wait    = ctl.ide_wait & rstn;
  assign hz.pc_hold     = ctl.pc_hold & rstn;
  assign hz.flush_if    = ctl.flush_if & rstn;
  assign hz.mem_err     = mem_err_q;
  assign hz.stall_count = stall_q;

endmodule
